traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised traffic-light controller, the next generation of the single-lamp cyclic controller. It sequences `NUM_DIR` approach directions round-robin through all-red clearance, green and yellow phases, with per-phase dwell times counted in prescaled ticks. It also serves a latched pedestrian request with an all-red walk phase. It sits between the board tick prescaler and the lamp and walk-signal drivers.

## Interface
- `NUM_DIR`, default 2: number of directions, legal range 2–4.
- `CNT_W`, default 8: dwell counter width. Every dwell parameter must be ≤ 2^CNT_W.
- `GREEN_TICKS`, default 20: green dwell in ticks, ≥ 1.
- `YELLOW_TICKS`, default 4: yellow dwell in ticks, ≥ 1.
- `ALLRED_TICKS`, default 2: clearance dwell in ticks, ≥ 1.
- `PED_TICKS`, default 10: walk dwell in ticks, ≥ 1.

Ports:
- `clk`  in  1  system clock. One clock only.
- `rst`  in  1  reset, synchronous and active-high.
- `tick_en`  in  1  one-cycle dwell strobe from the prescaler. Tie high for cycle-rate counting.
- `ped_req`  in  1  pedestrian request, level or pulse, sampled every cycle.
- `light`  out  3*NUM_DIR  lamp field. Direction i occupies bits [3i+2:3i], encoded red=3'b100, green=3'b010, yellow=3'b001.
- `walk`  out  1  walk lamp, high only in the PED state.
- `cur_dir`  out  $clog2(NUM_DIR)  index of the direction being served.
- `ped_pending`  out  1  latched pedestrian request not yet served.

## Operation
- States: ALL_RED, GREEN, YELLOW, PED.
- ALL_RED (ALLRED_TICKS):
  - if `ped_pending` is set and the previous state was YELLOW, go to PED;
  - otherwise go to GREEN for `cur_dir`.
- GREEN (GREEN_TICKS): go to YELLOW.
- YELLOW (YELLOW_TICKS): go to ALL_RED, and `cur_dir` advances modulo NUM_DIR (NUM_DIR-1 wraps to 0).
- PED (PED_TICKS): go to ALL_RED. That ALL_RED is followed by GREEN, never a second PED.
- Lamp outputs:
  - `cur_dir` shows green or yellow only in GREEN or YELLOW.
  - Every other direction, and every direction in ALL_RED and PED, shows red.
  - At no time are two directions non-red.
- Pedestrian latch:
  - Set on any cycle with `ped_req`=1.
  - Cleared on the cycle PED is entered.
  - If `ped_req` is high on the entry cycle, set wins, so one further walk is pending.
  - A request during PED sets the latch for the next eligible slot.
- Dwell counter:
  - Increments only on `tick_en`=1.
  - On `tick_en` with count == DUR-1, the state changes at that edge and the counter clears.
  - With `tick_en`=0 the counter and state hold.
- Outputs decode from registered state and are glitch-free. There is no combinational path from inputs to outputs.

## Timing
- Reset (`rst` high at an edge):
  - state=ALL_RED, `cur_dir`=0, counter=0, latch=0;
  - `light` all-red (every field 3'b100), `walk`=0, `ped_pending`=0;
  - all effective from that edge.
- `rst` asserted mid-phase aborts the phase immediately. The next edge after release begins a full ALLRED_TICKS count.
- `rst` has priority over `tick_en` and `ped_req` in the same cycle.
- With `tick_en` tied high, phase durations in clock cycles equal the parameters exactly.
- One full rotation without pedestrian service is NUM_DIR × (ALLRED+GREEN+YELLOW) ticks.
- `ped_pending` rises the cycle after `ped_req` is sampled and falls on the edge entering PED.

## Structure
- Package `traffic_pkg`:
  - state enum (ALL_RED, GREEN, YELLOW, PED);
  - lamp constants LAMP_RED, LAMP_GREEN, LAMP_YELLOW (3 bits);
  - a function building the `light` field from state and `cur_dir`.
- Sub-module `dwell_timer`:
  - counter with `tick_en` and a load-duration input;
  - `done` output asserted when count == dur-1 and `tick_en` is high.
- The top level holds the FSM, the `cur_dir` register, the pedestrian latch and the output decode.

## Test plan
Configuration for all scenarios: NUM_DIR=2, GREEN=4, YELLOW=2, ALLRED=1, PED=3, `tick_en`=1.

- Reset:
  - stimulus: `rst` high for 2 cycles.
  - response: `light`=6'b100_100, `walk`=0, `cur_dir`=0.
  - After release: 1 cycle all-red, then `light`=6'b100_010 for 4 cycles, then 6'b100_001 for 2 cycles.
- Rotation:
  - stimulus: run 14 cycles after reset release.
  - response: dir1 green (`light`=6'b010_100) appears at cycles 8–11, and `cur_dir` wraps to 0 at cycle 14.
  - Check mutual exclusion of non-red directions every cycle.
- Pedestrian:
  - stimulus: one-cycle `ped_req` during dir0 green.
  - response: after dir0 yellow and 1 all-red cycle, `walk`=1 for 3 cycles with all red. Then 1 all-red cycle, then dir1 green.
- Simultaneous request:
  - stimulus: `ped_req` held through PED entry.
  - response: `ped_pending` stays 1, and a second walk occurs after the dir1 yellow.
- Tick gating:
  - stimulus: `tick_en` toggling 1/0 each cycle.
  - response: every phase length doubles and outputs hold during `tick_en`=0.
- Mid-phase reset:
  - stimulus: assert `rst` during the PED state.
  - response: `walk` drops and `light` is all red at the same edge, `ped_pending`=0, then the sequence restarts from dir0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and lamp encoding for the traffic phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    PED     = 2'd3
  } state_t;

  localparam int unsigned MAX_DIR = 4;
  localparam int unsigned LAMP_W  = 3;
  localparam int unsigned FIELD_W = MAX_DIR * LAMP_W;

  localparam logic [LAMP_W-1:0] LAMP_RED    = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_GREEN  = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_YELLOW = 3'b001;

  // Lamp field for the widest configuration; callers keep the low 3*NUM_DIR bits.
  function automatic logic [FIELD_W-1:0] light_field(input state_t st, input logic [1:0] dir);
    logic [FIELD_W-1:0] f;
    for (int i = 0; i < MAX_DIR; i++) begin
      f[LAMP_W*i +: LAMP_W] = LAMP_RED;
      if (2'(i) == dir) begin
        if (st == GREEN) begin
          f[LAMP_W*i +: LAMP_W] = LAMP_GREEN;
        end else if (st == YELLOW) begin
          f[LAMP_W*i +: LAMP_W] = LAMP_YELLOW;
        end
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_dwell_timer.sv
// Tick-gated dwell counter; done fires on the tick that completes the dwell.
module dwell_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_en,
  input  logic [CNT_W:0] dur,
  output logic           done
);

  logic [CNT_W-1:0] count;

  // dur may equal 2^CNT_W, so the terminal value dur-1 still fits in CNT_W bits.
  assign done = tick_en && (count == CNT_W'(dur - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (done) begin
      count <= '0;
    end else if (tick_en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic phase sequencer with latched pedestrian all-red walk phase.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned NUM_DIR      = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_TICKS  = 20,
  parameter int unsigned YELLOW_TICKS = 4,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned PED_TICKS    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_en,
  input  logic                         ped_req,
  output logic [3*NUM_DIR-1:0]         light,
  output logic                         walk,
  output logic [$clog2(NUM_DIR)-1:0]   cur_dir,
  output logic                         ped_pending
);

  localparam int unsigned DIR_W   = $clog2(NUM_DIR);
  localparam int unsigned LIGHT_W = 3 * NUM_DIR;
  localparam int unsigned DUR_W   = CNT_W + 1;

  state_t           state;
  state_t           state_nxt;
  logic [DIR_W-1:0] dir_nxt;
  logic             from_yellow;
  logic             from_yellow_nxt;
  logic             pend_nxt;
  logic             ped_enter;
  logic [DUR_W-1:0] dur;
  logic             done;

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .tick_en (tick_en),
    .dur     (dur),
    .done    (done)
  );

  // State register plus registered lamp decode of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALL_RED;
      cur_dir     <= '0;
      from_yellow <= 1'b0;
      ped_pending <= 1'b0;
      light       <= LIGHT_W'(light_field(ALL_RED, 2'd0));
      walk        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_dir     <= dir_nxt;
      from_yellow <= from_yellow_nxt;
      ped_pending <= pend_nxt;
      light       <= LIGHT_W'(light_field(state_nxt, 2'(dir_nxt)));
      walk        <= (state_nxt == PED);
    end
  end

  always_comb begin
    state_nxt       = state;
    dir_nxt         = cur_dir;
    from_yellow_nxt = from_yellow;
    dur             = DUR_W'(ALLRED_TICKS);

    case (state)
      ALL_RED: begin
        dur = DUR_W'(ALLRED_TICKS);
        if (done) begin
          // Walk is only granted in the clearance that follows a yellow.
          state_nxt       = (ped_pending && from_yellow) ? PED : GREEN;
          from_yellow_nxt = 1'b0;
        end
      end
      GREEN: begin
        dur = DUR_W'(GREEN_TICKS);
        if (done) begin
          state_nxt       = YELLOW;
          from_yellow_nxt = 1'b0;
        end
      end
      YELLOW: begin
        dur = DUR_W'(YELLOW_TICKS);
        if (done) begin
          state_nxt       = ALL_RED;
          from_yellow_nxt = 1'b1;
          dir_nxt         = (cur_dir == DIR_W'(NUM_DIR - 1)) ? '0 : cur_dir + 1'b1;
        end
      end
      PED: begin
        dur = DUR_W'(PED_TICKS);
        if (done) begin
          state_nxt       = ALL_RED;
          from_yellow_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ALL_RED;
      end
    endcase

    ped_enter = (state_nxt == PED) && (state != PED);
    // A request on the entry cycle wins over the clear.
    pend_nxt  = ped_req || (ped_pending && !ped_enter);
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized bench for traffic_phase_ctrl against a countdown-based phase model.
module tb_traffic_phase_ctrl;

  localparam int unsigned ND = 2;
  localparam int unsigned GT = 4;
  localparam int unsigned YT = 2;
  localparam int unsigned AT = 1;
  localparam int unsigned PT = 3;

  logic       clk;
  logic       rst;
  logic       tick_en;
  logic       ped_req;
  logic [5:0] light;
  logic       walk;
  logic [0:0] cur_dir;
  logic       ped_pending;

  int n_vec;
  int n_err;

  // Model: phase 0=all-red 1=green 2=yellow 3=walk, ticks remaining in phase.
  int m_ph;
  int m_last;
  int m_dir;
  int m_rem;
  bit m_pend;

  traffic_phase_ctrl #(
    .NUM_DIR      (ND),
    .CNT_W        (8),
    .GREEN_TICKS  (GT),
    .YELLOW_TICKS (YT),
    .ALLRED_TICKS (AT),
    .PED_TICKS    (PT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_en     (tick_en),
    .ped_req     (ped_req),
    .light       (light),
    .walk        (walk),
    .cur_dir     (cur_dir),
    .ped_pending (ped_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur_of(input int ph);
    case (ph)
      1: return GT;
      2: return YT;
      3: return PT;
      default: return AT;
    endcase
  endfunction

  function automatic logic [5:0] exp_light();
    logic [5:0] f;
    for (int d = 0; d < ND; d++) begin
      f[3*d +: 3] = 3'b100;
      if (d == m_dir && m_ph == 1) f[3*d +: 3] = 3'b010;
      if (d == m_dir && m_ph == 2) f[3*d +: 3] = 3'b001;
    end
    return f;
  endfunction

  task automatic model_step(input bit r, input bit t, input bit p);
    bit enter;
    int nxt;
    if (r) begin
      m_ph = 0; m_last = 0; m_dir = 0; m_rem = AT; m_pend = 0;
      return;
    end
    enter = 0;
    if (t) begin
      m_rem--;
      if (m_rem == 0) begin
        nxt = 0;
        case (m_ph)
          0: if (m_pend && m_last == 2) begin nxt = 3; enter = 1; end else nxt = 1;
          1: nxt = 2;
          2: begin nxt = 0; m_dir = (m_dir + 1) % ND; end
          default: nxt = 0;
        endcase
        m_last = m_ph;
        m_ph   = nxt;
        m_rem  = dur_of(nxt);
      end
    end
    m_pend = p || (m_pend && !enter);
  endtask

  task automatic step(input bit r, input bit t, input bit p);
    int nonred;
    @(negedge clk);
    rst = r; tick_en = t; ped_req = p;
    @(posedge clk);
    model_step(r, t, p);
    #1;
    check_val("light", 32'(light), 32'(exp_light()));
    check_val("walk", 32'(walk), 32'(m_ph == 3));
    check_val("cur_dir", 32'(cur_dir), 32'(m_dir));
    check_val("ped_pending", 32'(ped_pending), 32'(m_pend));
    nonred = 0;
    for (int d = 0; d < ND; d++) begin
      if (light[3*d +: 3] != 3'b100) nonred++;
    end
    check_val("exclusive", 32'(nonred <= 1), 32'd1);
  endtask

  logic [5:0] rot_tab [14];
  bit found;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; tick_en = 1'b1; ped_req = 1'b0;
    m_ph = 0; m_last = 0; m_dir = 0; m_rem = AT; m_pend = 0;
    rot_tab = '{6'o42, 6'o42, 6'o42, 6'o42, 6'o41, 6'o41, 6'o44,
                6'o24, 6'o24, 6'o24, 6'o24, 6'o14, 6'o14, 6'o44};

    // Reset held two cycles.
    step(1, 1, 0);
    step(1, 1, 0);
    check_val("rst_light", 32'(light), 32'h24);
    check_val("rst_walk", 32'(walk), 32'd0);
    check_val("rst_dir", 32'(cur_dir), 32'd0);

    // One full rotation against the fixed expected lamp sequence.
    for (int k = 0; k < 14; k++) begin
      step(0, 1, 0);
      check_val("rot_light", 32'(light), 32'(rot_tab[k]));
      if (k == 12) check_val("rot_dir1", 32'(cur_dir), 32'd1);
      if (k == 13) check_val("rot_wrap", 32'(cur_dir), 32'd0);
    end

    // Single pedestrian pulse during dir0 green.
    step(0, 1, 0);
    step(0, 1, 1);
    check_val("ped_latched", 32'(ped_pending), 32'd1);
    for (int k = 0; k < 20; k++) step(0, 1, 0);

    // Request held across walk entry, then released.
    for (int k = 0; k < 25; k++) step(0, 1, 1);
    for (int k = 0; k < 30; k++) step(0, 1, 0);

    // Tick gating at half rate, with an occasional request.
    for (int k = 0; k < 60; k++) step(0, (k % 2) == 0, (k == 7));

    // Random ticks, requests and rare resets.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    // Reset mid-walk: issue a request then wait (bounded) for the walk phase.
    step(0, 1, 1);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      step(0, 1, 0);
      if (m_ph == 3) found = 1;
    end
    check_val("ped_reached", 32'(found), 32'd1);
    step(1, 1, 1);
    check_val("midrst_walk", 32'(walk), 32'd0);
    check_val("midrst_light", 32'(light), 32'h24);
    check_val("midrst_pend", 32'(ped_pending), 32'd0);
    for (int k = 0; k < 10; k++) step(0, 1, 0);
    check_val("restart_dir", 32'(cur_dir), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
